// File: rtl/uart_time_set_ctrl.sv
// Serial time-set sequencer: collects HHMMSS + CR from the UART receiver, validates the
// entry and hands packed BCD time to the timekeeping counter with a one-cycle load strobe.
module uart_time_set_ctrl #(
  parameter logic [3:0] SET_STATE   = 4'd10,
  parameter logic [3:0] MENU_STATE  = 4'd9,
  parameter int         TIMEOUT_CYC = 2_000_000
) (
  input  logic        clk1mhz,
  input  logic        reset,
  input  logic [3:0]  state,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [23:0] time_bcd,
  output logic        load_pulse,
  output logic        busy,
  output logic        err,
  output logic [2:0]  digit_cnt
);

  localparam int          TW   = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]  CH_BS = 8'h08;
  localparam logic [7:0]  CH_CR = 8'h0D;

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_WAIT_CR, S_CHECK, S_LOAD, S_DONE, S_ERROR
  } fsm_t;

  fsm_t            fsm_q, fsm_d;
  logic [5:0][3:0] dbuf_q, dbuf_d;   // element 5 is slot0 (HT), element 0 is slot5 (SU)
  logic [2:0]      cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [23:0]     tbcd_q, tbcd_d;
  logic            is_digit, is_bs, is_cr, range_ok;

  assign is_digit = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
  assign is_bs    = (rx_byte == CH_BS);
  assign is_cr    = (rx_byte == CH_CR);

  // MU and SU need no test: any single digit is legal there.
  assign range_ok = (dbuf_q[5] <= 4'd2) &&
                    (dbuf_q[4] <= ((dbuf_q[5] == 4'd2) ? 4'd3 : 4'd9)) &&
                    (dbuf_q[3] <= 4'd5) &&
                    (dbuf_q[1] <= 4'd5);

  always_ff @(posedge clk1mhz or negedge reset) begin
    if (!reset) fsm_q <= S_IDLE;
    else        fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d  = fsm_q;
    dbuf_d = dbuf_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    tmr_d  = tmr_q;
    tbcd_d = tbcd_q;
    if (state == MENU_STATE) begin
      fsm_d  = S_IDLE;
      dbuf_d = '0;
      cnt_d  = '0;
      err_d  = 1'b0;
      tmr_d  = '0;
    end else if (state != SET_STATE) begin
      fsm_d = S_IDLE;
      tmr_d = '0;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          fsm_d = S_COLLECT;
          cnt_d = '0;
          err_d = 1'b0;
          tmr_d = '0;
        end
        S_COLLECT, S_WAIT_CR: begin
          if (rx_valid) begin
            tmr_d = '0;
            if (is_digit) begin
              if (fsm_q == S_WAIT_CR) begin
                fsm_d = S_ERROR;
                err_d = 1'b1;
                cnt_d = '0;
              end else begin
                dbuf_d[3'd5 - cnt_q] = rx_byte[3:0];
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd5) fsm_d = S_WAIT_CR;
              end
            end else if (is_bs) begin
              if (fsm_q == S_WAIT_CR) begin
                fsm_d = S_COLLECT;
                cnt_d = 3'd5;
              end else if (cnt_q != 3'd0) begin
                cnt_d = cnt_q - 3'd1;
              end
            end else if (is_cr) begin
              if (fsm_q == S_WAIT_CR) begin
                fsm_d = S_CHECK;
              end else begin
                fsm_d = S_ERROR;
                err_d = 1'b1;
                cnt_d = '0;
              end
            end
          end else if (tmr_q == TMAX) begin
            fsm_d = S_ERROR;
            err_d = 1'b1;
            cnt_d = '0;
            tmr_d = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        S_CHECK: begin
          // Latch time here so time_bcd is already valid during the load strobe.
          if (range_ok) begin
            fsm_d  = S_LOAD;
            tbcd_d = dbuf_q;
          end else begin
            fsm_d = S_ERROR;
            err_d = 1'b1;
            cnt_d = '0;
          end
        end
        S_LOAD:  fsm_d = S_DONE;
        S_DONE:  fsm_d = S_DONE;
        S_ERROR: begin
          if (rx_valid && is_digit) begin
            fsm_d     = S_COLLECT;
            dbuf_d[5] = rx_byte[3:0];
            cnt_d     = 3'd1;
            err_d     = 1'b0;
            tmr_d     = '0;
          end
        end
        default: fsm_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk1mhz or negedge reset) begin
    if (!reset) begin
      dbuf_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      tmr_q  <= '0;
      tbcd_q <= '0;
    end else begin
      dbuf_q <= dbuf_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      tmr_q  <= tmr_d;
      tbcd_q <= tbcd_d;
    end
  end

  assign time_bcd   = tbcd_q;
  assign load_pulse = (fsm_q == S_LOAD);
  assign busy       = (fsm_q == S_COLLECT) || (fsm_q == S_WAIT_CR) ||
                      (fsm_q == S_CHECK)   || (fsm_q == S_LOAD);
  assign err        = err_q;
  assign digit_cnt  = cnt_q;

endmodule
